// File: rtl/hash_req_arbiter.sv
// Round-robin arbiter feeding one tabulation-hash engine; a tag pipeline routes each
// returned hash back to the requester that issued it as a one-hot result strobe.
module hash_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HASH_LAT = 2,
  parameter int TUPLE_W  = 104,
  parameter int HASH_W   = 32
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TUPLE_W-1:0] req_tuple,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       arb_en,
  output logic [TUPLE_W-1:0]         eng_tuple,
  output logic                       eng_valid,
  input  logic [HASH_W-1:0]          eng_hash,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [HASH_W-1:0]          res_hash,
  output logic [31:0]                grant_cnt,
  output logic                       idle
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]               ptr;
  logic [IDX_W-1:0]               gnt_idx;
  logic [IDX_W:0]                 cand_sum;
  logic [IDX_W-1:0]               cand;
  logic                           found;
  logic                           xfer;
  // Stage 0 is the engine issue cycle; stage HASH_LAT lines up with eng_hash.
  logic [HASH_LAT:0]              vld_pipe;
  logic [HASH_LAT:0][IDX_W-1:0]   idx_pipe;

  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (!found && arb_en && axi_aresetn && req_valid[cand]) begin
        found          = 1'b1;
        req_ready[cand] = 1'b1;
        gnt_idx        = cand;
      end
    end
  end

  assign xfer      = found;
  assign eng_valid = vld_pipe[0];
  assign idle      = ~|vld_pipe & ~|res_valid;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ptr       <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      eng_tuple <= '0;
      res_valid <= '0;
      res_hash  <= '0;
      grant_cnt <= '0;
    end else begin
      vld_pipe <= {vld_pipe[HASH_LAT-1:0], xfer};
      idx_pipe <= {idx_pipe[HASH_LAT-1:0], gnt_idx};
      if (xfer) begin
        eng_tuple <= req_tuple[gnt_idx*TUPLE_W +: TUPLE_W];
        grant_cnt <= grant_cnt + 32'd1;
        ptr       <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      res_valid <= vld_pipe[HASH_LAT] ? (NUM_REQ'(1) << idx_pipe[HASH_LAT]) : '0;
      if (vld_pipe[HASH_LAT]) res_hash <= eng_hash;
    end
  end
endmodule
